magnitude_comparator: RTL and testbench
=======================================

// Module: magnitude_comparator
// PURPOSE
//   Registered WIDTH-bit magnitude comparator: compares operands A and B, raises exactly one of
//   AeqB / AgtB / AltB one clock after a valid input. Unsigned or two's-complement (SIGNED).
//   Cascade inputs chain instances for wider words (less-significant slice feeds cas_*).
//   Generic compare primitive for datapath and control logic.
// PARAMETERS
//   WIDTH   8   operand width in bits, >= 1
//   SIGNED  0   0 = unsigned compare; 1 = two's-complement compare
// PORTS
//   clk       in   1      rising-edge clock; the only clock
//   rst       in   1      synchronous reset, active-high
//   in_valid  in   1      A, B, cas_* valid this cycle
//   A         in   WIDTH  operand A
//   B         in   WIDTH  operand B
//   cas_gt    in   1      lower-slice result A>B; tie 0 when standalone
//   cas_lt    in   1      lower-slice result A<B; tie 0 when standalone
//   out_valid out  1      AeqB/AgtB/AltB hold a new result this cycle
//   AeqB      out  1      registered A == B
//   AgtB      out  1      registered A > B
//   AltB      out  1      registered A < B
// BEHAVIOUR
//   - One clock, sync active-high reset. rst=1 at an edge: out_valid=0, AeqB=0, AgtB=0, AltB=0;
//     overrides in_valid in the same cycle; an in-flight compare is discarded.
//   - Latency 1: in_valid=1 at edge N -> out_valid=1 and result on outputs after edge N.
//     No back-pressure; a new compare accepted every cycle.
//   - in_valid=0: out_valid=0 next cycle; AeqB/AgtB/AltB hold the last result.
//   - SIGNED=0: A, B unsigned 0..2^WIDTH-1. SIGNED=1: MSB is sign, range -2^(WIDTH-1)..2^(WIDTH-1)-1.
//   - A != B: AgtB = (A > B), AltB = (A < B), AeqB = 0; cas_* ignored.
//   - A == B: cascade decides. cas_gt=1 -> AgtB=1; else cas_lt=1 -> AltB=1; else AeqB=1.
//     cas_gt=cas_lt=1 is illegal upstream; resolved as gt (cas_gt priority).
//   - After reset and any accepted compare, exactly one of AeqB/AgtB/AltB is 1 (one-hot).
//   - Pure combinational compare + one register stage; no state machine. Full-range values
//     (0, all-ones, most-negative when SIGNED) compare correctly with no overflow.
//   - WIDTH=1: 1-bit compare, same rules (SIGNED=1: 1 is -1 < 0).
// TESTING
//   - Reset: rst=1 two cycles with in_valid=1, A=10, B=10 -> out_valid=0, all flags 0; deassert
//     -> next compare honoured.
//   - Equality: WIDTH=8, A=10, B=10, cas=00 -> cycle after: out_valid=1, AeqB=1, AgtB=0, AltB=0.
//   - Greater/less: A=15,B=10 -> AgtB=1; then A=10,B=15 -> AltB=1; back-to-back, each 1 cycle later.
//   - Signed vs unsigned: A=8'hFF, B=8'h01: SIGNED=0 -> AgtB=1; SIGNED=1 -> AltB=1.
//     Also A=8'h80, B=8'h7F, SIGNED=1 -> AltB=1.
//   - Cascade: A=B=8'h33, cas_gt=1 -> AgtB=1; cas_lt=1 -> AltB=1; both 1 -> AgtB=1;
//     A=8'h34,B=8'h33,cas_lt=1 -> AgtB=1.
//   - Hold/reset mid-run: result AltB=1, then in_valid=0 -> out_valid=0, AltB stays 1;
//     rst=1 -> all 0.
//   - Every cycle: assert out_valid implies one-hot flags; random A/B vs reference model.

Source files
------------

// File: rtl/magnitude_comparator.sv
// Registered WIDTH-bit magnitude comparator with cascade inputs for chaining slices.
// Produces one-hot AeqB/AgtB/AltB one clock after each valid operand pair.
module magnitude_comparator #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cas_gt,
  input  logic             cas_lt,
  output logic             out_valid,
  output logic             AeqB,
  output logic             AgtB,
  output logic             AltB
);

  // Returns {a_gt_b, a_lt_b} for this slice alone.
  function automatic logic [1:0] slice_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    if (SIGNED != 0) slice_cmp = {sa > sb, sa < sb};
    else             slice_cmp = {a > b, a < b};
  endfunction

  // Equal slices defer to the lower slice; cas_gt wins if both cascade inputs are set.
  function automatic logic [2:0] resolve(input logic [1:0] cmp, input logic cg, input logic cl);
    if (cmp[1])      resolve = 3'b010;
    else if (cmp[0]) resolve = 3'b001;
    else if (cg)     resolve = 3'b010;
    else if (cl)     resolve = 3'b001;
    else             resolve = 3'b100;
  endfunction

  logic       vld_p1_d;
  logic       vld_p1_q;
  logic [2:0] flags_p1_d;
  logic [2:0] flags_p1_q;

  // Stage 0 -> 1: combinational compare, captured only when the input is valid.
  always_comb begin
    vld_p1_d   = in_valid;
    flags_p1_d = flags_p1_q;
    if (in_valid) flags_p1_d = resolve(slice_cmp(A, B), cas_gt, cas_lt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      flags_p1_q <= 3'b000;
    end else begin
      vld_p1_q   <= vld_p1_d;
      flags_p1_q <= flags_p1_d;
    end
  end

  assign out_valid = vld_p1_q;
  assign AeqB      = flags_p1_q[2];
  assign AgtB      = flags_p1_q[1];
  assign AltB      = flags_p1_q[0];

endmodule

// File: tb/tb_magnitude_comparator.sv
// Bench for magnitude_comparator: unsigned and signed instances share stimulus,
// expected results flow through per-instance scoreboard queues.
module tb_magnitude_comparator;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         cas_gt = 1'b0;
  logic         cas_lt = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ov_u, eq_u, gt_u, lt_u;
  logic         ov_s, eq_s, gt_s, lt_s;

  logic [2:0] q_u[$];
  logic [2:0] q_s[$];
  logic [2:0] held_u = 3'b000;
  logic [2:0] held_s = 3'b000;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  magnitude_comparator #(.WIDTH(W), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
    .cas_gt(cas_gt), .cas_lt(cas_lt),
    .out_valid(ov_u), .AeqB(eq_u), .AgtB(gt_u), .AltB(lt_u)
  );

  magnitude_comparator #(.WIDTH(W), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
    .cas_gt(cas_gt), .cas_lt(cas_lt),
    .out_valid(ov_s), .AeqB(eq_s), .AgtB(gt_s), .AltB(lt_s)
  );

  // Reference: widen to 32-bit int (sign- or zero-extended) and compare there.
  function automatic logic [2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic cg, input logic cl, input bit sgn);
    int ix;
    int iy;
    if (sgn) begin
      ix = {{(32-W){x[W-1]}}, x};
      iy = {{(32-W){y[W-1]}}, y};
    end else begin
      ix = {{(32-W){1'b0}}, x};
      iy = {{(32-W){1'b0}}, y};
    end
    if (ix > iy) return 3'b010;
    if (ix < iy) return 3'b001;
    if (cg)      return 3'b010;
    if (cl)      return 3'b001;
    return 3'b100;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed={vld,eq,gt,lt}=%b expected=%b", tag, obs, exp);
  endtask

  task automatic step(input string tag, input logic r, input logic v,
                      input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic cg, input logic cl);
    logic exp_v;
    @(negedge clk);
    rst = r; in_valid = v; a = x; b = y; cas_gt = cg; cas_lt = cl;
    if (r) begin
      q_u.delete();
      q_s.delete();
    end else if (v) begin
      q_u.push_back(model(x, y, cg, cl, 1'b0));
      q_s.push_back(model(x, y, cg, cl, 1'b1));
    end
    @(posedge clk);
    #1;
    exp_v = v & ~r;
    if (r) begin
      held_u = 3'b000;
      held_s = 3'b000;
    end else if (ov_u || ov_s || v) begin
      if (q_u.size() != 0) held_u = q_u.pop_front();
      if (q_s.size() != 0) held_s = q_s.pop_front();
    end
    check({tag, "_u"}, {ov_u, eq_u, gt_u, lt_u}, {exp_v, held_u});
    check({tag, "_s"}, {ov_s, eq_s, gt_s, lt_s}, {exp_v, held_s});
    if (ov_u) check({tag, "_onehot_u"}, {3'b000, $onehot({eq_u, gt_u, lt_u})}, 4'b0001);
    if (ov_s) check({tag, "_onehot_s"}, {3'b000, $onehot({eq_s, gt_s, lt_s})}, 4'b0001);
  endtask

  initial begin
    step("rst0", 1'b1, 1'b1, 8'd10, 8'd10, 1'b0, 1'b0);
    step("rst1", 1'b1, 1'b1, 8'd10, 8'd10, 1'b0, 1'b0);
    step("eq",   1'b0, 1'b1, 8'd10, 8'd10, 1'b0, 1'b0);
    step("gt",   1'b0, 1'b1, 8'd15, 8'd10, 1'b0, 1'b0);
    step("lt",   1'b0, 1'b1, 8'd10, 8'd15, 1'b0, 1'b0);
    step("ff_01", 1'b0, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
    step("80_7f", 1'b0, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b0);
    step("cas_gt",   1'b0, 1'b1, 8'h33, 8'h33, 1'b1, 1'b0);
    step("cas_lt",   1'b0, 1'b1, 8'h33, 8'h33, 1'b0, 1'b1);
    step("cas_both", 1'b0, 1'b1, 8'h33, 8'h33, 1'b1, 1'b1);
    step("cas_ign",  1'b0, 1'b1, 8'h34, 8'h33, 1'b0, 1'b1);
    step("hold_lt",  1'b0, 1'b1, 8'd10, 8'd15, 1'b0, 1'b0);
    step("hold1",    1'b0, 1'b0, 8'd99, 8'd1,  1'b1, 1'b0);
    step("hold2",    1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0);
    step("rst_mid",  1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0);
    step("rst_drop", 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
    step("z_ff",     1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0);
    step("z_z",      1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    step("ff_ff",    1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    step("80_80",    1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 1'b1);
    step("7f_80",    1'b0, 1'b1, 8'h7F, 8'h80, 1'b0, 1'b0);
    step("80_00",    1'b0, 1'b1, 8'h80, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] rx;
      logic [W-1:0] ry;
      rx = 8'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? rx : 8'($urandom);
      step("rand", 1'b0, $urandom_range(0, 3) != 0, rx, ry,
           1'($urandom), 1'($urandom));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
